// File: rtl/core_pkg.sv
// Shared definitions for the core-to-AHB-Lite bridge: bus encodings,
// request size codes, bridge states and the request legality check.
package core_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [1:0] SIZE_BYTE    = 2'b00;
   localparam logic [1:0] SIZE_HALF    = 2'b01;
   localparam logic [1:0] SIZE_WORD    = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_RESP
   } bridge_state_e;

   function automatic logic [2:0] to_hsize(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return HSIZE_BYTE;
         SIZE_HALF: return HSIZE_HALF;
         default:   return HSIZE_WORD;
      endcase
   endfunction

   // True for an illegal size code or an address not aligned to the size.
   function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_HALF:    return addr_lo[0];
         SIZE_WORD:    return addr_lo != 2'b00;
         SIZE_ILLEGAL: return 1'b1;
         default:      return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_bridge_if.sv
// Request port from the core plus the AHB-Lite master signals.
// master = the bridge; slave = core and interconnect side.
interface ahb_bridge_if;

   logic        req_rd_en;
   logic        req_wr_en;
   logic [31:0] req_addr;
   logic [31:0] req_wr_data;
   logic [1:0]  req_size;
   logic [31:0] req_rd_data;
   logic        req_rd_vld;
   logic        req_busy;
   logic        req_err;

   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   modport master (
      input  req_rd_en, req_wr_en, req_addr, req_wr_data, req_size,
      output req_rd_data, req_rd_vld, req_busy, req_err,
      output HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      output req_rd_en, req_wr_en, req_addr, req_wr_data, req_size,
      input  req_rd_data, req_rd_vld, req_busy, req_err,
      input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
      output HRDATA, HREADY, HRESP
   );

endinterface

// File: rtl/ahb_lane_mux.sv
// Byte-lane steering keyed by transfer size and address[1:0]: replicates
// write data across lanes and extracts/zero-extends the addressed read lane.
module ahb_lane_mux
   import core_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   always_comb begin
      wdata_o = wdata_i;
      rdata_o = rdata_i;
      case (size_i)
         SIZE_BYTE: begin
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {24'h0, rdata_i[{addr_lo_i, 3'b000} +: 8]};
         end
         SIZE_HALF: begin
            wdata_o = {2{wdata_i[15:0]}};
            rdata_o = {16'h0, rdata_i[{addr_lo_i[1], 4'b0000} +: 16]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ahb_bridge.sv
// Runs one core load/store request at a time as a single NONSEQ AHB-Lite
// transfer, with size/alignment rejection, error response and stall timeout.
module ahb_bridge
   import core_pkg::*;
#(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic         clk,
   input  logic         rst_n,
   ahb_bridge_if.master bus
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   bridge_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] haddr_q, haddr_d;
   logic [1:0]  htrans_q, htrans_d;
   logic        hwrite_q, hwrite_d;
   logic [2:0]  hsize_q, hsize_d;
   logic [31:0] hwdata_q, hwdata_d;
   logic [31:0] rd_data_q, rd_data_d;
   logic        rd_vld_q, rd_vld_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;

   logic [31:0] lane_wdata;
   logic [31:0] lane_rdata;
   logic        stall_limit;

   ahb_lane_mux u_lane_mux (
      .size_i    (hsize_q[1:0]),
      .addr_lo_i (haddr_q[1:0]),
      .wdata_i   (wdata_q),
      .rdata_i   (bus.HRDATA),
      .wdata_o   (lane_wdata),
      .rdata_o   (lane_rdata)
   );

   assign stall_limit = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         wdata_q   <= '0;
         haddr_q   <= '0;
         htrans_q  <= HTRANS_IDLE;
         hwrite_q  <= 1'b0;
         hsize_q   <= '0;
         hwdata_q  <= '0;
         rd_data_q <= '0;
         rd_vld_q  <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wdata_q   <= wdata_d;
         haddr_q   <= haddr_d;
         htrans_q  <= htrans_d;
         hwrite_q  <= hwrite_d;
         hsize_q   <= hsize_d;
         hwdata_q  <= hwdata_d;
         rd_data_q <= rd_data_d;
         rd_vld_q  <= rd_vld_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      wdata_d   = wdata_q;
      haddr_d   = haddr_q;
      hwrite_d  = hwrite_q;
      hsize_d   = hsize_q;
      hwdata_d  = hwdata_q;
      rd_data_d = rd_data_q;
      rd_vld_d  = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE, ST_RESP: begin
            state_d = ST_IDLE;
            if (bus.req_rd_en || bus.req_wr_en) begin
               if ((bus.req_rd_en && bus.req_wr_en) || req_bad(bus.req_size, bus.req_addr[1:0])) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  if (bus.req_rd_en) rd_data_d = '0;
               end else begin
                  state_d  = ST_ADDR;
                  haddr_d  = bus.req_addr;
                  hwrite_d = bus.req_wr_en;
                  hsize_d  = to_hsize(bus.req_size);
                  wdata_d  = bus.req_wr_data;
               end
            end
         end
         ST_ADDR: begin
            if (bus.HREADY) begin
               state_d  = ST_DATA;
               hwdata_d = lane_wdata;
            end else if (stall_limit) begin
               state_d = ST_RESP;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (bus.HREADY) begin
               state_d = ST_RESP;
               if (bus.HRESP) begin
                  err_d = 1'b1;
                  if (!hwrite_q) rd_data_d = '0;
               end else if (!hwrite_q) begin
                  rd_vld_d  = 1'b1;
                  rd_data_d = lane_rdata;
               end
            end else if (stall_limit) begin
               state_d = ST_RESP;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered outputs follow the next state so they align with it.
      htrans_d = (state_d == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      busy_d   = (state_d == ST_ADDR) || (state_d == ST_DATA);
   end

   assign bus.HADDR       = haddr_q;
   assign bus.HTRANS      = htrans_q;
   assign bus.HWRITE      = hwrite_q;
   assign bus.HSIZE       = hsize_q;
   assign bus.HWDATA      = hwdata_q;
   assign bus.req_rd_data = rd_data_q;
   assign bus.req_rd_vld  = rd_vld_q;
   assign bus.req_busy    = busy_q;
   assign bus.req_err     = err_q;

endmodule

// File: tb/tb_ahb_bridge.sv
// Bench for ahb_bridge: directed scenarios plus randomized transfers checked
// cycle by cycle against an arithmetic model of the request/response rules.
module tb_ahb_bridge;

   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ahb_bridge_if bus();

   ahb_bridge #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rep_model(input logic [31:0] d, input logic [1:0] sz);
      if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] ext_model(input logic [31:0] hr, input logic [31:0] a, input logic [1:0] sz);
      int unsigned lane;
      lane = a % 4;
      if (sz == 2'd0) return (hr >> (8 * lane)) & 32'hFF;
      if (sz == 2'd1) return (hr >> (16 * (lane / 2))) & 32'hFFFF;
      return hr;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_htrans"}, 32'(bus.HTRANS), 32'h0);
      chk({tag, "_haddr"}, bus.HADDR, 32'h0);
      chk({tag, "_hwrite"}, 32'(bus.HWRITE), 32'h0);
      chk({tag, "_hsize"}, 32'(bus.HSIZE), 32'h0);
      chk({tag, "_hwdata"}, bus.HWDATA, 32'h0);
      chk({tag, "_rdata"}, bus.req_rd_data, 32'h0);
      chk({tag, "_rdvld"}, 32'(bus.req_rd_vld), 32'h0);
      chk({tag, "_busy"}, 32'(bus.req_busy), 32'h0);
      chk({tag, "_err"}, 32'(bus.req_err), 32'h0);
   endtask

   // Slave side: aw/dw wait states in address/data phase; eresp gives a
   // two-cycle ERROR response; noise drives ignored requests while busy.
   task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic [31:0] hr,
                          input int unsigned aw, input int unsigned dw,
                          input bit eresp, input bit noise, input bit b2b);
      bit reject;
      bit done;
      bit in_data;
      int unsigned cnt;
      int unsigned bytes;
      bytes  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      reject = (rd && wr) || (sz == 2'd3) || ((addr % bytes) != 0);

      bus.req_rd_en   = rd;
      bus.req_wr_en   = wr;
      bus.req_addr    = addr;
      bus.req_wr_data = wd;
      bus.req_size    = sz;
      bus.HRDATA      = hr;
      bus.HREADY      = 1'b1;
      bus.HRESP       = 1'b0;
      step();
      bus.req_rd_en = 1'b0;
      bus.req_wr_en = 1'b0;

      if (reject) begin
         chk("rej_err", 32'(bus.req_err), 32'h1);
         chk("rej_busy", 32'(bus.req_busy), 32'h0);
         chk("rej_htrans", 32'(bus.HTRANS), 32'h0);
         chk("rej_rdvld", 32'(bus.req_rd_vld), 32'h0);
         if (rd) chk("rej_rdata", bus.req_rd_data, 32'h0);
      end else begin
         chk("addr_htrans", 32'(bus.HTRANS), 32'h2);
         chk("addr_busy", 32'(bus.req_busy), 32'h1);
         chk("addr_haddr", bus.HADDR, addr);
         chk("addr_hwrite", 32'(bus.HWRITE), 32'(wr));
         chk("addr_hsize", 32'(bus.HSIZE), 32'(sz));
         chk("addr_err", 32'(bus.req_err), 32'h0);
         in_data = 1'b0;
         done    = 1'b0;
         cnt     = 0;
         for (int unsigned cyc = 0; cyc < 40 && !done; cyc++) begin
            if (noise) begin
               bus.req_rd_en = 1'b1;
               bus.req_addr  = $urandom;
               bus.req_size  = 2'($urandom_range(0, 2));
            end
            if (!in_data) begin
               bus.HREADY = (cnt == aw);
               bus.HRESP  = 1'b0;
            end else begin
               bus.HREADY = (cnt == dw);
               bus.HRESP  = eresp && (cnt + 1 >= dw);
            end
            step();
            bus.req_rd_en = 1'b0;
            if (bus.HREADY && !in_data) begin
               in_data = 1'b1;
               cnt     = 0;
               chk("data_htrans", 32'(bus.HTRANS), 32'h0);
               chk("data_busy", 32'(bus.req_busy), 32'h1);
               chk("data_err", 32'(bus.req_err), 32'h0);
               if (wr) chk("data_hwdata", bus.HWDATA, rep_model(wd, sz));
            end else if (bus.HREADY) begin
               done = 1'b1;
               chk("resp_busy", 32'(bus.req_busy), 32'h0);
               chk("resp_htrans", 32'(bus.HTRANS), 32'h0);
               if (eresp) begin
                  chk("resp_err", 32'(bus.req_err), 32'h1);
                  chk("resp_rdvld", 32'(bus.req_rd_vld), 32'h0);
                  if (rd) chk("resp_rdata0", bus.req_rd_data, 32'h0);
               end else begin
                  chk("resp_err", 32'(bus.req_err), 32'h0);
                  chk("resp_rdvld", 32'(bus.req_rd_vld), 32'(rd));
                  if (rd) chk("resp_rdata", bus.req_rd_data, ext_model(hr, addr, sz));
               end
            end else begin
               cnt++;
               if (cnt == TO) begin
                  done = 1'b1;
                  chk("to_err", 32'(bus.req_err), 32'h1);
                  chk("to_busy", 32'(bus.req_busy), 32'h0);
                  chk("to_htrans", 32'(bus.HTRANS), 32'h0);
                  chk("to_rdvld", 32'(bus.req_rd_vld), 32'h0);
               end else begin
                  chk("wait_htrans", 32'(bus.HTRANS), in_data ? 32'h0 : 32'h2);
                  chk("wait_busy", 32'(bus.req_busy), 32'h1);
                  chk("wait_err", 32'(bus.req_err), 32'h0);
                  chk("wait_rdvld", 32'(bus.req_rd_vld), 32'h0);
               end
            end
         end
         if (!done) chk("txn_cycle_budget", 32'h0, 32'h1);
      end
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      if (!b2b) begin
         step();
         chk("idle_busy", 32'(bus.req_busy), 32'h0);
         chk("idle_err", 32'(bus.req_err), 32'h0);
         chk("idle_rdvld", 32'(bus.req_rd_vld), 32'h0);
         chk("idle_htrans", 32'(bus.HTRANS), 32'h0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic        r, w;
      logic [31:0] a, d, h;
      logic [1:0]  sz;
      int unsigned k, aw, dw;
      bit          er;

      bus.req_rd_en   = 1'b0;
      bus.req_wr_en   = 1'b0;
      bus.req_addr    = '0;
      bus.req_wr_data = '0;
      bus.req_size    = '0;
      bus.HRDATA      = '0;
      bus.HREADY      = 1'b1;
      bus.HRESP       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("por");
      #3 rst_n = 1'b1;
      step();

      run_txn(1, 0, 32'h0000_1000, 32'h0, 2'd2, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      run_txn(0, 1, 32'h0000_2003, 32'h0000_00A5, 2'd0, 32'h0, 1, 1, 0, 0, 0);
      run_txn(1, 0, 32'h0000_3002, 32'h0, 2'd1, 32'h1234_ABCD, 0, 0, 0, 0, 0);
      run_txn(1, 0, 32'h0000_3001, 32'h0, 2'd0, 32'h1234_ABCD, 0, 1, 0, 1, 0);
      run_txn(0, 1, 32'h0000_4002, 32'hCAFE_F00D, 2'd2, 32'h0, 0, 0, 0, 0, 0);
      run_txn(1, 1, 32'h0000_4000, 32'h0, 2'd2, 32'h0, 0, 0, 0, 0, 0);
      run_txn(1, 0, 32'h0000_4000, 32'h0, 2'd3, 32'h0, 0, 0, 0, 0, 0);
      run_txn(1, 0, 32'h0000_5001, 32'h0, 2'd1, 32'h0, 0, 0, 0, 0, 0);
      run_txn(1, 0, 32'h0000_6004, 32'h0, 2'd2, 32'h5555_AAAA, 0, 1, 1, 0, 0);
      run_txn(1, 0, 32'h0000_7000, 32'h0, 2'd2, 32'h0, 0, TO, 0, 0, 0);
      run_txn(0, 1, 32'h0000_7000, 32'h1, 2'd2, 32'h0, TO + 1, 0, 0, 0, 0);
      run_txn(1, 0, 32'h0000_8000, 32'h0, 2'd2, 32'h0102_0304, 0, 0, 0, 0, 1);
      run_txn(0, 1, 32'h0000_8002, 32'h0000_BEEF, 2'd1, 32'h0, 0, 0, 0, 0, 1);
      run_txn(1, 0, 32'h0000_8003, 32'h0, 2'd0, 32'h8899_AABB, 0, 0, 0, 0, 0);

      // Asynchronous reset in the data phase of a read.
      run_txn(1, 0, 32'h0000_9000, 32'h0, 2'd2, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
      bus.req_rd_en = 1'b1;
      bus.req_addr  = 32'h0000_9104;
      bus.req_size  = 2'd2;
      step();
      bus.req_rd_en = 1'b0;
      step();
      chk("rst_pre_busy", 32'(bus.req_busy), 32'h1);
      bus.HREADY = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_vals("midrst");
      #3 rst_n = 1'b1;
      bus.HREADY = 1'b1;
      step();
      chk("postrst_busy", 32'(bus.req_busy), 32'h0);
      chk("postrst_htrans", 32'(bus.HTRANS), 32'h0);

      for (int i = 0; i < 300; i++) begin
         k  = $urandom_range(0, 15);
         r  = (k < 7) || (k == 15);
         w  = (k >= 7);
         sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         a  = $urandom;
         if ($urandom_range(0, 9) < 7) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         d  = $urandom;
         h  = $urandom;
         aw = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 1) : $urandom_range(0, 2);
         dw = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 1) : $urandom_range(0, 2);
         er = ($urandom_range(0, 7) == 0);
         run_txn(r, w, a, d, sz, h, aw, dw, er, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ahb_bridge.md
# ahb_bridge

Bus-side responder for the core's simple load/store request port (rd_en/wr_en/addr/wr_data/size in; rd_data/rd_vld/busy out). It accepts one request at a time and runs it as a single NONSEQ AHB-Lite master transfer. It performs byte-lane replication on writes and lane extraction on reads, and reports misaligned, illegal, error-response and timed-out accesses on a one-cycle error pulse. It sits between the processor core and the system AHB-Lite interconnect.

## Interface
- TIMEOUT, 256: max consecutive HREADY=0 cycles in one transfer before abort; range 2..65535.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_rd_en  in  1  read request pulse from core.
- req_wr_en  in  1  write request pulse from core.
- req_addr  in  32  byte address.
- req_wr_data  in  32  write data, right-aligned.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_rd_data  out  32  read data, right-aligned, zero-extended.
- req_rd_vld  out  1  one-cycle pulse, req_rd_data valid.
- req_busy  out  1  request in flight; new requests ignored.
- req_err  out  1  one-cycle pulse, access failed.
- HADDR  out  32; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HWDATA  out  32.
- HRDATA  in  32; HREADY  in  1; HRESP  in  1.

## Operation
- States: IDLE, ADDR, DATA, RESP. Reset → IDLE.
- A request is accepted in IDLE or RESP when exactly one of rd_en/wr_en is high. addr, size, data and direction are latched. Next state is ADDR.
- The request is rejected, with no bus transfer, if:
  - rd_en and wr_en are both high, or
  - size=11, or
  - it is misaligned (half with addr[0]=1; word with addr[1:0]≠0).
  - Rejection: next state RESP with err set; rd_data=0 for reads.
- ADDR: HTRANS=NONSEQ (10) and HADDR/HWRITE/HSIZE={0,size} are driven. On HREADY=1 → DATA.
- DATA: HTRANS=IDLE (00) and HWDATA are driven. On HREADY=1 → RESP.
  - Reads capture HRDATA and extract the lane: byte = HRDATA[8*a+7:8*a] with a=addr[1:0]; half = HRDATA[16*addr[1]+15 : 16*addr[1]].
  - HRESP=1 with HREADY=1 → err. Read data is forced to 0, no rd_vld pulse.
- Write replication: byte → {4{d[7:0]}}; half → {2{d[15:0]}}; word → d.
- RESP: lasts one cycle. rd_vld pulses (successful read) or err pulses. busy=0. Returns to IDLE unless a new request is accepted.
- Timeout: a counter runs while in ADDR/DATA with HREADY=0 and clears on state change.
  - On reaching TIMEOUT: HTRANS is forced IDLE, next state RESP, err pulses.
- HTRANS is never BUSY/SEQ. HPROT, HBURST and HMASTLOCK are fixed outside this block (SINGLE, unlocked).

## Timing
- All outputs are registered.
- Reset values: HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0, req_rd_data=0, req_rd_vld=0, req_busy=0, req_err=0.
- Request sampled at edge E0 → busy=1 and ADDR from E0.
- Zero-wait read: DATA from E1, RESP from E2. rd_vld and rd_data valid in the cycle after E2. Total 3 cycles from request to data.
- Each HREADY=0 cycle adds one cycle.
- Rejected request: err pulses in the cycle after acceptance; busy stays 0.
- busy is high exactly in ADDR and DATA.
- Back-to-back: a request in the RESP cycle enters ADDR at the next edge, giving 3 cycles per zero-wait access.
- Reset mid-transfer: all outputs return to reset values immediately. The slave sees HTRANS=IDLE.
- Requests while busy=1 are dropped silently. The core must hold off.

## Structure
- Shared package (core_pkg): HTRANS_IDLE/NONSEQ, HSIZE codes, req_size encodings, bridge state enum.
- Sub-module ahb_lane_mux: combinational write replication and read extraction, keyed by size/addr[1:0]. Reused later by on-chip RAM slaves.
- Timeout counter: $clog2(TIMEOUT+1) bits, inline.

## Test plan
- Word read 0x0000_1000, HRDATA=0xDEADBEEF, zero wait:
  - HTRANS=10 for one cycle, HSIZE=010.
  - rd_vld with 0xDEADBEEF 3 cycles after request; busy high 2 cycles.
- Byte write addr 0x..03, data 0x000000A5, 2 wait states:
  - HWDATA=0xA5A5A5A5, HSIZE=000.
  - busy high 4 cycles, no rd_vld, no err.
- Half read addr 0x..02, HRDATA=0x1234ABCD:
  - rd_data=0x00001234.
  - Byte read addr 0x..01 of same data → 0x000000AB.
- Word write addr 0x..02, and rd_en+wr_en together:
  - No HTRANS=10.
  - err pulses in the cycle after the request; busy stays 0.
- HRESP error on read (HRESP=1/HREADY=0, then HRESP=1/HREADY=1):
  - err pulse, rd_data=0, no rd_vld.
- HREADY held 0 with TIMEOUT=4:
  - err after 4 stall cycles; HTRANS=00 thereafter.
  - Assert rst_n low mid-DATA on a second run → all outputs at reset values immediately.
